// File: rtl/mmv_regfile_responder_pkg.sv
// ---------------------------------------------------------------------------
// mmv_pkg
//   Definitions shared by the MMV family of blocks (initiators, synchronizers,
//   responders).
//   - mmv_cmd_e     : decoded command accepted in the current cycle
//   - mmv_cnt_width : bits needed for a counter that holds values 0..n
//   - legal ranges for the read latency and the wait-state count
// ---------------------------------------------------------------------------
package mmv_pkg;

    localparam int MMV_RDLAT_MIN   = 1;
    localparam int MMV_RDLAT_MAX   = 16;
    localparam int MMV_WSTATES_MAX = 15;

    typedef enum logic [1:0] {
        MMV_IDLE  = 2'd0,
        MMV_WRITE = 2'd1,
        MMV_READ  = 2'd2
    } mmv_cmd_e;

    // Width of a counter that must represent 0..n inclusive.
    function automatic int mmv_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mmv_regfile_responder_if.sv
// ---------------------------------------------------------------------------
// mmv_regfile_responder_if
//   MMV memory-mapped bus bundle.
//   master modport: drives s_addr/s_wreq/s_wdat/s_rreq, receives s_rdat/s_rval/s_busy
//   slave  modport: the reverse (used by mmv_regfile_responder)
//   s_addr  word address        s_wreq  write request     s_wdat  write data
//   s_rreq  read request        s_rdat  read data         s_rval  read strobe
//   s_busy  responder busy; requests are ignored while high
// ---------------------------------------------------------------------------
interface mmv_regfile_responder_if #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
);
    logic [AWIDTH-1:0] s_addr;
    logic              s_wreq;
    logic [DWIDTH-1:0] s_wdat;
    logic              s_rreq;
    logic [DWIDTH-1:0] s_rdat;
    logic              s_rval;
    logic              s_busy;

    modport master (
        output s_addr, s_wreq, s_wdat, s_rreq,
        input  s_rdat, s_rval, s_busy
    );

    modport slave (
        input  s_addr, s_wreq, s_wdat, s_rreq,
        output s_rdat, s_rval, s_busy
    );
endinterface

// File: rtl/mmv_rd_pipeline.sv
// ---------------------------------------------------------------------------
// mmv_rd_pipeline
//   RDLAT-deep valid+data delay line for read responses.
//   clk      in  clock, rising edge
//   reset_n  in  asynchronous active-low reset; clears every stage
//   i_val    in  a word enters stage 1 at this edge
//   i_dat    in  word entering the pipeline
//   o_val    out valid RDLAT cycles after i_val
//   o_dat    out delayed word; holds its last value while o_val = 0
// ---------------------------------------------------------------------------
module mmv_rd_pipeline #(
    parameter int DWIDTH = 8,
    parameter int RDLAT  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_val,
    input  logic [DWIDTH-1:0] i_dat,
    output logic              o_val,
    output logic [DWIDTH-1:0] o_dat
);
    logic [RDLAT:1]             vld_pipe;
    logic [RDLAT:1][DWIDTH-1:0] dat_pipe;

    // Data stages load only behind a valid bit, so every stage (and the
    // output in particular) keeps its last word when nothing is moving.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= i_val;
            if (i_val) dat_pipe[1] <= i_dat;
            for (int k = 2; k <= RDLAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign o_val = vld_pipe[RDLAT];
    assign o_dat = dat_pipe[RDLAT];
endmodule

// File: rtl/mmv_regfile_responder.sv
// ---------------------------------------------------------------------------
// mmv_regfile_responder
//   MMV slave holding a 2**AWIDTH x DWIDTH register file. Reads answer after
//   RDLAT clocks; every accepted command is followed by WSTATES busy cycles.
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset (memory, pipeline, busy)
//   s        slave modport of mmv_regfile_responder_if
// ---------------------------------------------------------------------------
module mmv_regfile_responder
    import mmv_pkg::*;
#(
    parameter int AWIDTH  = 4,
    parameter int DWIDTH  = 8,
    parameter int RDLAT   = 2,
    parameter int WSTATES = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mmv_regfile_responder_if.slave  s
);
    localparam int DEPTH = 2**AWIDTH;

    if (RDLAT < MMV_RDLAT_MIN || RDLAT > MMV_RDLAT_MAX) begin : g_bad_rdlat
        $error("mmv_regfile_responder: RDLAT=%0d outside 1..16", RDLAT);
    end
    if (WSTATES < 0 || WSTATES > MMV_WSTATES_MAX) begin : g_bad_wstates
        $error("mmv_regfile_responder: WSTATES=%0d outside 0..15", WSTATES);
    end

    logic [DWIDTH-1:0] mem [DEPTH];
    mmv_cmd_e          cmd;
    logic              busy;
    logic              wacc;
    logic              racc;
    logic              rd_val;
    logic [DWIDTH-1:0] rd_dat;

    // Write wins when both requests are raised; the read is dropped.
    always_comb begin
        cmd = MMV_IDLE;
        if (!busy) begin
            if (s.s_wreq)      cmd = MMV_WRITE;
            else if (s.s_rreq) cmd = MMV_READ;
        end
    end

    assign wacc = (cmd == MMV_WRITE);
    assign racc = (cmd == MMV_READ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wacc) begin
            mem[s.s_addr] <= s.s_wdat;
        end
    end

    if (WSTATES == 0) begin : g_no_busy
        assign busy = 1'b0;
    end else begin : g_busy
        localparam int BW = mmv_cnt_width(WSTATES);
        logic [BW-1:0] busy_cnt;
        logic          busy_q;

        // busy_q is the registered form of (busy_cnt != 0): it is set with the
        // load and cleared on the edge where the count steps from 1 to 0.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                busy_cnt <= '0;
                busy_q   <= 1'b0;
            end else if (wacc || racc) begin
                busy_cnt <= BW'(WSTATES);
                busy_q   <= 1'b1;
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - BW'(1);
                busy_q   <= (busy_cnt != BW'(1));
            end
        end

        assign busy = busy_q;
    end

    // Busy only gates acceptance; responses already in flight keep moving.
    mmv_rd_pipeline #(
        .DWIDTH (DWIDTH),
        .RDLAT  (RDLAT)
    ) u_rd_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .i_val   (racc),
        .i_dat   (mem[s.s_addr]),
        .o_val   (rd_val),
        .o_dat   (rd_dat)
    );

    assign s.s_rval = rd_val;
    assign s.s_rdat = rd_dat;
    assign s.s_busy = busy;
endmodule

// File: tb/tb_mmv_regfile_responder.sv
// ---------------------------------------------------------------------------
// tb_mmv_regfile_responder
//   Three responders share clk/reset_n:
//     inst 0: RDLAT=2 WSTATES=0   inst 1: RDLAT=3 WSTATES=0   inst 2: RDLAT=4 WSTATES=2
//   Directed table + hand sequences, then random traffic on all three against
//   a cycle-indexed reference model (memory array, response schedule, free-at time).
// ---------------------------------------------------------------------------
module tb_mmv_regfile_responder;
    localparam int RCYC = 400;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mmv_regfile_responder_if #(.AWIDTH(4), .DWIDTH(8)) b0 ();
    mmv_regfile_responder_if #(.AWIDTH(4), .DWIDTH(8)) b1 ();
    mmv_regfile_responder_if #(.AWIDTH(4), .DWIDTH(8)) b2 ();

    mmv_regfile_responder #(.AWIDTH(4), .DWIDTH(8), .RDLAT(2), .WSTATES(0))
        u0 (.clk(clk), .reset_n(reset_n), .s(b0));
    mmv_regfile_responder #(.AWIDTH(4), .DWIDTH(8), .RDLAT(3), .WSTATES(0))
        u1 (.clk(clk), .reset_n(reset_n), .s(b1));
    mmv_regfile_responder #(.AWIDTH(4), .DWIDTH(8), .RDLAT(4), .WSTATES(2))
        u2 (.clk(clk), .reset_n(reset_n), .s(b2));

    typedef struct {
        logic       rval;
        logic [7:0] rdat;
        logic       busy;
    } out_t;

    typedef struct {
        int         inst;
        logic       w;
        logic       r;
        logic [3:0] a;
        logic [7:0] d;
        logic       ev;
        logic [7:0] ed;
        logic       eb;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];

    // reference model state
    logic [7:0] mm      [3][16];
    int         free_at [3];
    logic [7:0] last_rd [3];
    logic       due_v   [3][RCYC+8];
    logic [7:0] due_d   [3][RCYC+8];
    logic       bsy_now [3];

    function automatic int rl_of(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int ws_of(input int i);
        return (i == 2) ? 2 : 0;
    endfunction

    function automatic out_t get_out(input int i);
        out_t o;
        case (i)
            0:       begin o.rval = b0.s_rval; o.rdat = b0.s_rdat; o.busy = b0.s_busy; end
            1:       begin o.rval = b1.s_rval; o.rdat = b1.s_rdat; o.busy = b1.s_busy; end
            default: begin o.rval = b2.s_rval; o.rdat = b2.s_rdat; o.busy = b2.s_busy; end
        endcase
        return o;
    endfunction

    task automatic drive(input int i, input logic w, input logic r,
                         input logic [3:0] a, input logic [7:0] d);
        case (i)
            0:       begin b0.s_wreq = w; b0.s_rreq = r; b0.s_addr = a; b0.s_wdat = d; end
            1:       begin b1.s_wreq = w; b1.s_rreq = r; b1.s_addr = a; b1.s_wdat = d; end
            default: begin b2.s_wreq = w; b2.s_rreq = r; b2.s_addr = a; b2.s_wdat = d; end
        endcase
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_reset();
        idle_all();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Waits for the slave to be free, issues one read and checks latency/data.
    task automatic read_check(input int i, input logic [3:0] a, input logic [7:0] e,
                              input string nm);
        out_t o;
        int   n;
        n = 0;
        o = get_out(i);
        while (o.busy && n < 32) begin tick(); n++; o = get_out(i); end
        chk({nm, "_idle"}, o.busy, 0);
        drive(i, 1'b0, 1'b1, a, 8'h00);
        tick();
        drive(i, 1'b0, 1'b0, 4'h0, 8'h00);
        n = 1;
        o = get_out(i);
        while (!o.rval && n < 40) begin tick(); n++; o = get_out(i); end
        chk({nm, "_lat"}, n, rl_of(i));
        chk({nm, "_rval"}, o.rval, 1);
        chk({nm, "_rdat"}, o.rdat, e);
        tick();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 16; a++) mm[i][a] = 8'h00;
            for (int c = 0; c < RCYC + 8; c++) begin due_v[i][c] = 1'b0; due_d[i][c] = 8'h00; end
            free_at[i] = 0;
            last_rd[i] = 8'h00;
        end
    endtask

    task automatic fill_table();
        // inst 0: write A5 to addr 3, read it next cycle, response 2 cycles later
        tbl.push_back('{0, 1'b1, 1'b0, 4'h3, 8'hA5, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b1, 4'h3, 8'h00, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'hA5, 1'b0});
        tbl.push_back('{0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'hA5, 1'b0});
        // inst 1: fill addr 0..7, then stream 8 reads; responses 3 cycles later
        for (int r = 0; r < 20; r++) begin
            vec_t v;
            v.inst = 1;
            v.w    = (r < 8);
            v.r    = (r >= 8 && r < 16);
            v.a    = 4'(r % 8);
            v.d    = 8'(8'h30 + r);
            v.ev   = (r >= 11 && r <= 18);
            v.ed   = (r < 11) ? 8'h00 : (r <= 18) ? 8'(8'h30 + r - 11) : 8'h37;
            v.eb   = 1'b0;
            tbl.push_back(v);
        end
        // inst 2: write held 9 cycles; only cycles 0, 3, 6 are accepted
        for (int r = 0; r < 10; r++) begin
            vec_t v;
            v.inst = 2;
            v.w    = (r < 9);
            v.r    = 1'b0;
            v.a    = 4'(r);
            v.d    = 8'(8'h10 + r);
            v.ev   = 1'b0;
            v.ed   = 8'h00;
            v.eb   = (r % 3 != 0);
            tbl.push_back(v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        out_t o;
        reset_n = 1'b0;
        idle_all();
        fill_table();

        // 1. reset held with random inputs
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++)
                drive(i, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
            tick();
            for (int i = 0; i < 3; i++) begin
                o = get_out(i);
                chk($sformatf("rst_rval[%0d]", i), o.rval, 0);
                chk($sformatf("rst_busy[%0d]", i), o.busy, 0);
                chk($sformatf("rst_rdat[%0d]", i), o.rdat, 0);
            end
        end
        idle_all();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++)
            read_check(i, 4'($urandom), 8'h00, $sformatf("post_rst_rd[%0d]", i));

        // 2-4. directed table
        pulse_reset();
        foreach (tbl[k]) begin
            o = get_out(tbl[k].inst);
            chk($sformatf("tbl%0d_rval", k), o.rval, tbl[k].ev);
            chk($sformatf("tbl%0d_rdat", k), o.rdat, tbl[k].ed);
            chk($sformatf("tbl%0d_busy", k), o.busy, tbl[k].eb);
            idle_all();
            drive(tbl[k].inst, tbl[k].w, tbl[k].r, tbl[k].a, tbl[k].d);
            tick();
        end
        idle_all();
        for (int a = 0; a < 9; a++)
            read_check(2, 4'(a), (a % 3 == 0) ? 8'(8'h10 + a) : 8'h00,
                       $sformatf("throttle_rd%0d", a));

        // 5. simultaneous write+read acts as a write, no response
        drive(0, 1'b1, 1'b1, 4'h5, 8'h3C);
        tick();
        idle_all();
        for (int k = 1; k <= rl_of(0) + 2; k++) begin
            o = get_out(0);
            chk($sformatf("wr_rd_norval%0d", k), o.rval, 0);
            tick();
        end
        read_check(0, 4'h5, 8'h3C, "wr_rd_mem");

        // 6. reset in the middle of a read (inst 1) and a busy window (inst 2)
        drive(1, 1'b1, 1'b0, 4'h9, 8'h77);
        tick();
        drive(1, 1'b0, 1'b1, 4'h9, 8'h00);
        drive(2, 1'b1, 1'b0, 4'h1, 8'h55);
        tick();
        idle_all();
        o = get_out(2);
        chk("midrst_busy_before", o.busy, 1);
        reset_n = 1'b0;
        #1;
        o = get_out(2);
        chk("midrst_busy_async", o.busy, 0);
        o = get_out(1);
        chk("midrst_rval_async", o.rval, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < rl_of(1) + 3; k++) begin
            o = get_out(1);
            chk($sformatf("midrst_norval%0d", k), o.rval, 0);
            o = get_out(2);
            chk($sformatf("midrst_nobusy%0d", k), o.busy, 0);
            tick();
        end
        read_check(1, 4'h9, 8'h00, "midrst_mem1");
        read_check(2, 4'h1, 8'h00, "midrst_mem2");

        // random traffic against the reference model
        pulse_reset();
        model_reset();
        for (int n = 0; n < RCYC; n++) begin
            for (int i = 0; i < 3; i++) begin
                logic ev;
                o          = get_out(i);
                bsy_now[i] = (n < free_at[i]);
                ev         = due_v[i][n];
                if (ev) last_rd[i] = due_d[i][n];
                chk($sformatf("rnd%0d_rval@%0d", i, n), o.rval, ev);
                chk($sformatf("rnd%0d_rdat@%0d", i, n), o.rdat, last_rd[i]);
                chk($sformatf("rnd%0d_busy@%0d", i, n), o.busy, bsy_now[i]);
            end
            for (int i = 0; i < 3; i++) begin
                logic       w, r;
                logic [3:0] a;
                logic [7:0] d;
                w = ($urandom_range(0, 9) < 3);
                r = ($urandom_range(0, 9) < 4);
                a = 4'($urandom);
                d = 8'($urandom);
                drive(i, w, r, a, d);
                if (!bsy_now[i] && (w || r)) begin
                    if (w) begin
                        mm[i][a] = d;
                    end else begin
                        due_v[i][n + rl_of(i)] = 1'b1;
                        due_d[i][n + rl_of(i)] = mm[i][a];
                    end
                    free_at[i] = n + ws_of(i) + 1;
                end
            end
            tick();
        end
        idle_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
